// File: rtl/arbitro_memoria.sv
// arbitro_memoria
// Shares one single-port data memory between the CPU (port C) and the
// video/sprite fetch engine (port V). One transaction at a time is run
// through a fixed LAT-cycle memory window; read data comes back with a
// one-cycle done pulse. Video has fixed priority, but a CPU that has waited
// MAX_WAIT cycles or more wins the next arbitration.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  CPU request (held stable until c_gnt)
//   c_gnt, c_done, c_rdata     CPU accept pulse, completion pulse, read data
//   v_*                        same set for the video engine
//   mem_addr/mem_we/mem_wdata  memory command (we pulses in first BUSY cycle)
//   mem_rdata                  memory read data
//   cnt_c, cnt_v               per-port grant counters (only with the option)
//
// Optional feature: define ARB_MEMORIA_STATS_EN to add the saturating 16-bit
// grant counters cnt_c / cnt_v.
module arbitro_memoria #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_wdata,
  output logic              v_gnt,
  output logic              v_done,
  output logic [DATA_W-1:0] v_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_MEMORIA_STATS_EN
  ,
  output logic [15:0]       cnt_c,
  output logic [15:0]       cnt_v
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic       OWN_C      = 1'b0;
  localparam logic       OWN_V      = 1'b1;
  localparam logic [3:0] LAST_CNT   = 4'(LAT - 1);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                owner_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [7:0]          wait_reg;
  logic [DATA_W-1:0]   c_rdata_reg, v_rdata_reg;
  logic                c_win, v_win;

  // CPU overrides video priority only once it has been starved long enough.
  assign c_win = c_req && (!v_req || (wait_reg >= MAX_WAIT_C));
  assign v_win = v_req && !c_win;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    c_gnt      = 1'b0;
    v_gnt      = 1'b0;
    c_done     = 1'b0;
    v_done     = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (c_win || v_win) begin
          c_gnt      = c_win;
          v_gnt      = v_win;
          state_next = BUSY;
          cnt_next   = 4'd0;
        end
      end
      BUSY: begin
        mem_we   = we_reg && (cnt_reg == 4'd0);
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_CNT) begin
          c_done     = (owner_reg == OWN_C);
          v_done     = (owner_reg == OWN_V);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A cycle in reset neither grants, completes nor strobes the memory.
    if (reset) begin
      c_gnt  = 1'b0;
      v_gnt  = 1'b0;
      c_done = 1'b0;
      v_done = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      owner_reg   <= OWN_C;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wait_reg    <= '0;
      c_rdata_reg <= '0;
      v_rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (c_gnt) begin
        owner_reg <= OWN_C;
        we_reg    <= c_we;
        addr_reg  <= c_addr;
        wdata_reg <= c_wdata;
      end else if (v_gnt) begin
        owner_reg <= OWN_V;
        we_reg    <= v_we;
        addr_reg  <= v_addr;
        wdata_reg <= v_wdata;
      end
      if (c_done && !we_reg) c_rdata_reg <= mem_rdata;
      if (v_done && !we_reg) v_rdata_reg <= mem_rdata;
      if (c_gnt)
        wait_reg <= '0;
      else if (c_req && (wait_reg != 8'hFF))
        wait_reg <= wait_reg + 8'd1;
    end
  end

  // The address register only changes on a grant, so the memory sees a
  // stable address in IDLE and no spurious strobe.
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  // During the done cycle the read data is forwarded straight from memory so
  // it is valid together with the pulse; afterwards the captured copy holds.
  assign c_rdata = (c_done && !we_reg) ? mem_rdata : c_rdata_reg;
  assign v_rdata = (v_done && !we_reg) ? mem_rdata : v_rdata_reg;

`ifdef ARB_MEMORIA_STATS_EN
  logic [1:0] gnt_vec;
  assign gnt_vec = {v_gnt, c_gnt};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [15:0] stat_reg;
      always_ff @(posedge clk) begin
        if (reset)
          stat_reg <= '0;
        else if (gnt_vec[gi] && (stat_reg != 16'hFFFF))
          stat_reg <= stat_reg + 16'd1;
      end
    end
  endgenerate

  assign cnt_c = g_stat[0].stat_reg;
  assign cnt_v = g_stat[1].stat_reg;
`else
  // Grant counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_arbitro_memoria.sv
module tb_arbitro_memoria;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int LAT      = 2;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              c_req, c_we, v_req, v_we;
  logic [ADDR_W-1:0] c_addr, v_addr, mem_addr;
  logic [DATA_W-1:0] c_wdata, v_wdata, c_rdata, v_rdata, mem_wdata, mem_rdata;
  logic              c_gnt, c_done, v_gnt, v_done, mem_we;
`ifdef ARB_MEMORIA_STATS_EN
  logic [15:0]       cnt_c, cnt_v;
`endif

  always #5 clk = ~clk;

  arbitro_memoria #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_gnt(v_gnt), .v_done(v_done), .v_rdata(v_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_MEMORIA_STATS_EN
    , .cnt_c(cnt_c), .cnt_v(cnt_v)
`endif
  );

  // Memory environment: combinational read of a small word array, write on strobe.
  logic [31:0] ram [256];
  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

  // Reference model: transaction-level view (cycles left in the current access).
  logic [31:0] ref_ram [256];
  int          m_left, m_wait, m_cnt_c, m_cnt_v;
  bit          m_owner_v, m_we;
  logic [31:0] m_addr, m_wdata, m_c_rdata, m_v_rdata;

  bit pend_c, pend_v, rand_en, hold_v;
  int cyc, t0, cgnt_cyc, vgnt_cyc, cdone_cyc, we_cnt;
  logic [31:0] we_addr, we_data;
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic new_c(input bit we, input logic [31:0] a, input logic [31:0] d);
    pend_c = 1'b1; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic new_v(input bit we, input logic [31:0] a, input logic [31:0] d);
    pend_v = 1'b1; v_we = we; v_addr = a; v_wdata = d;
  endtask

  task automatic model_reset();
    m_left = 0; m_wait = 0; m_cnt_c = 0; m_cnt_v = 0;
    m_owner_v = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_c_rdata = '0; m_v_rdata = '0;
  endtask

  // One clock cycle: drive requests, check against the model, advance the model.
  task automatic step();
    bit idle, last, e_cg, e_vg, e_cd, e_vd, e_we;
    @(negedge clk);
    if (rand_en && !pend_c && $urandom_range(0, 2) == 0)
      new_c(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom());
    if (rand_en && !pend_v && $urandom_range(0, 2) == 0)
      new_v(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom());
    if (hold_v && !pend_v)
      new_v(1'b0, 32'($urandom_range(0, 255)), $urandom());
    c_req = pend_c;
    v_req = pend_v;
    #1;
    idle = (m_left == 0);
    e_cg = !reset && idle && c_req && (!v_req || m_wait >= MAX_WAIT);
    e_vg = !reset && idle && v_req && !e_cg;
    e_we = !reset && (m_left == LAT) && m_we;
    last = !reset && (m_left == 1);
    e_cd = last && !m_owner_v;
    e_vd = last && m_owner_v;
    if (e_cd && !m_we) m_c_rdata = ref_ram[m_addr[7:0]];
    if (e_vd && !m_we) m_v_rdata = ref_ram[m_addr[7:0]];
    chk("c_gnt", 32'(c_gnt), 32'(e_cg));
    chk("v_gnt", 32'(v_gnt), 32'(e_vg));
    chk("one_gnt", 32'(c_gnt & v_gnt), 32'd0);
    chk("c_done", 32'(c_done), 32'(e_cd));
    chk("v_done", 32'(v_done), 32'(e_vd));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("c_rdata", c_rdata, m_c_rdata);
    chk("v_rdata", v_rdata, m_v_rdata);
`ifdef ARB_MEMORIA_STATS_EN
    chk("cnt_c", 32'(cnt_c), 32'(m_cnt_c));
    chk("cnt_v", 32'(cnt_v), 32'(m_cnt_v));
`endif
    if (c_gnt) begin cgnt_cyc = cyc; pend_c = 1'b0; end
    if (v_gnt) begin vgnt_cyc = cyc; pend_v = 1'b0; end
    if (c_done) cdone_cyc = cyc;
    if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (e_we) ref_ram[m_addr[7:0]] = m_wdata;
      if (m_left > 0) begin
        m_left--;
      end else if (e_cg || e_vg) begin
        m_left    = LAT;
        m_owner_v = e_vg;
        m_we      = e_cg ? c_we : v_we;
        m_addr    = e_cg ? c_addr : v_addr;
        m_wdata   = e_cg ? c_wdata : v_wdata;
        if (e_cg && m_cnt_c < 65535) m_cnt_c++;
        if (e_vg && m_cnt_v < 65535) m_cnt_v++;
      end
      if (e_cg) m_wait = 0;
      else if (c_req && m_wait < 255) m_wait++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    pend_c = 0; pend_v = 0; rand_en = 0; hold_v = 0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'hA500_0000 | 32'(i);
      ref_ram[i] = 32'hA500_0000 | 32'(i);
    end
    ram[8'h40] = 32'hDEADBEEF;
    ref_ram[8'h40] = 32'hDEADBEEF;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset: all outputs at reset values.
    step();

    // Single CPU read of 0x40.
    cgnt_cyc = -100; cdone_cyc = -1; we_cnt = 0;
    new_c(1'b0, 32'h40, 32'h0);
    repeat (5) step();
    chk("t1_gnt_to_done", 32'(cdone_cyc - cgnt_cyc), 32'(LAT));
    chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_no_we", 32'(we_cnt), 32'd0);

    // CPU write 0x10 <= 0x12345678, then read it back.
    we_cnt = 0;
    new_c(1'b1, 32'h10, 32'h12345678);
    repeat (5) step();
    chk("t2_we_cycles", 32'(we_cnt), 32'd1);
    chk("t2_we_addr", we_addr, 32'h10);
    chk("t2_we_data", we_data, 32'h12345678);
    chk("t2_rdata_kept", c_rdata, 32'hDEADBEEF);
    new_c(1'b0, 32'h10, 32'h0);
    repeat (5) step();
    chk("t2_readback", c_rdata, 32'h12345678);

    // Simultaneous requests: video first, CPU LAT+1 cycles later.
    reset = 1'b1; step(); reset = 1'b0;
    cgnt_cyc = -100; vgnt_cyc = -100;
    new_c(1'b0, 32'h21, 32'h0);
    new_v(1'b0, 32'h22, 32'h0);
    t0 = cyc;
    repeat (8) step();
    chk("t3_v_first", 32'(vgnt_cyc - t0), 32'd0);
    chk("t3_c_second", 32'(cgnt_cyc - t0), 32'(LAT + 1));

    // Video hogging: CPU wins at the first free slot once it has waited MAX_WAIT.
    reset = 1'b1; step(); reset = 1'b0;
    cgnt_cyc = -100;
    hold_v = 1'b1;
    new_c(1'b0, 32'h40, 32'h0);
    t0 = cyc;
    repeat (20) step();
    hold_v = 1'b0;
    chk("t4_starve_gnt", 32'(cgnt_cyc - t0),
        32'(((MAX_WAIT + LAT) / (LAT + 1)) * (LAT + 1)));
    repeat (8) step();

    // Reset in the first BUSY cycle of a read: aborted, no done.
    new_c(1'b0, 32'h40, 32'h0);
    step();
    cdone_cyc = -1;
    reset = 1'b1; step(); reset = 1'b0;
    repeat (4) step();
    chk("t5_no_done", 32'(cdone_cyc), 32'hFFFF_FFFF);
    chk("t5_addr_reset", mem_addr, 32'h0);
    chk("t5_rdata_reset", c_rdata, 32'h0);

    // Randomised traffic on both ports.
    rand_en = 1'b1;
    repeat (400) step();
    rand_en = 1'b0;
    repeat (12) step();

    // Grant statistics: 3 CPU and 5 video transactions from reset.
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      new_c(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom());
      repeat (LAT + 2) step();
    end
    for (int i = 0; i < 5; i++) begin
      new_v(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom());
      repeat (LAT + 2) step();
    end
`ifdef ARB_MEMORIA_STATS_EN
    chk("t6_cnt_c", 32'(cnt_c), 32'd3);
    chk("t6_cnt_v", 32'(cnt_v), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
